// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM state type, the x0 register
// index, and the all-zero control word used to inject NOP bubbles.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    localparam logic [4:0] X0 = 5'd0;

    // Control bits carried by ID/EX; a bubble loads all of them as zero.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [1:0] alu_op;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t NOP_CTRL = '0;

    // A write to x0 is discarded, so it can never create a true dependency.
    function automatic logic reg_dep(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Raw load-use hazard detection: the load in EX writes a register that the
// instruction in ID reads. Purely combinational; the controller qualifies it.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       uses_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    output logic       hazard_o
);

    // rs2 only counts when the ID instruction actually reads it.
    always_comb begin
        hazard_o = ex_mem_read_i &&
                   (reg_dep(ex_rd_i, rs1_i) || (uses_rs2_i && reg_dep(ex_rd_i, rs2_i)));
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush/freeze controller for the 5-stage core.
// Priority: memory freeze, then taken-branch flush, then load-use stall.
// A memory wait longer than MEM_TIMEOUT cycles locks into TIMEOUT until reset.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall/flush/freeze
// performance counters.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned WAIT_W      = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             IF_ID_UsesRs2,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_MEM_BranchTaken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
`endif
);

    // Elaboration-time parameter sanity checks.
    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("MEM_TIMEOUT must lie in 2..255");
    end
    if (WAIT_W < 2 || WAIT_W > 16 || MEM_TIMEOUT > (2 ** WAIT_W) - 1) begin : g_bad_wait_w
        $error("WAIT_W too narrow for MEM_TIMEOUT");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WaitOne  = WAIT_W'(1);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic raw_hazard;
    logic mem_stall;
    logic freeze;
    logic flush;
    logic load_use;

    load_use_detect u_load_use_detect (
        .rs1_i         (IF_ID_Rs1),
        .rs2_i         (IF_ID_Rs2),
        .uses_rs2_i    (IF_ID_UsesRs2),
        .ex_rd_i       (ID_EX_Rd),
        .ex_mem_read_i (ID_EX_MemRead),
        .hazard_o      (raw_hazard)
    );

    // Qualify the raw hazard and branch against the freeze in priority order.
    always_comb begin
        mem_stall = mem_req && !mem_ready;
        freeze    = (state_q == TIMEOUT) || mem_stall;
        flush     = !freeze && EX_MEM_BranchTaken;
        load_use  = !freeze && !EX_MEM_BranchTaken && raw_hazard;
    end

    // Next-state logic for the memory-wait watchdog.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WaitOne;
                end
            end
            MEM_WAIT: begin
                // Completion beats the watchdog in the same cycle; a dropped
                // request is an aborted access.
                if (mem_ready || !mem_req) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d    = TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitOne;
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Mealy outputs for the PC and pipeline-register controls.
    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        id_ex_write     = 1'b1;
        ex_mem_write    = 1'b1;
        id_ex_bubble    = 1'b0;
        mem_wb_bubble   = 1'b0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;
        flush_ex_mem    = 1'b0;
        mem_timeout_err = (state_q == TIMEOUT);
        if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (flush) begin
            // PC stays enabled so the redirect target is fetched.
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (load_use && stall_cnt_q != CntMax) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (flush && flush_cnt_q != CntMax) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
            if (freeze && freeze_cnt_q != CntMax) begin
                freeze_cnt_q <= freeze_cnt_q + CntOne;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central pipeline-control block for the 5-stage pipelined CPU. It sequences stalls, flushes and freezes across the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards that MEM/WB forwarding cannot cover, flushes wrong-path instructions on a taken branch, and freezes the whole pipeline while the data memory port is busy, with a watchdog on that wait. It sits beside the forwarding unit and drives the write-enable and flush inputs of the PC and all pipeline registers.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive cycles allowed in MEM_WAIT before a fatal timeout (legal range 2..255).
WAIT_W, 8, width of the internal wait counter; must hold MEM_TIMEOUT.
CNT_W, 16, width of the performance counters (optional feature only).

Ports:
clk  in  1  core clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
IF_ID_Rs1  in  5  rs1 of the instruction in ID.
IF_ID_Rs2  in  5  rs2 of the instruction in ID.
IF_ID_UsesRs2  in  1  instruction in ID reads rs2 (R/S/B type).
ID_EX_Rd  in  5  destination register of the instruction in EX.
ID_EX_MemRead  in  1  instruction in EX is a load.
EX_MEM_BranchTaken  in  1  branch or jump resolved taken in the MEM stage.
mem_req  in  1  MEM-stage instruction is accessing data memory this cycle.
mem_ready  in  1  data memory completes the access this cycle.
pc_write  out  1  PC update enable.
if_id_write  out  1  IF/ID register write enable.
id_ex_write  out  1  ID/EX register write enable.
ex_mem_write  out  1  EX/MEM register write enable.
id_ex_bubble  out  1  load the ID/EX register with a NOP (control bits zeroed).
mem_wb_bubble  out  1  load the MEM/WB register with a NOP.
flush_if_id  out  1  clear IF/ID.
flush_id_ex  out  1  clear ID/EX.
flush_ex_mem  out  1  clear EX/MEM.
mem_timeout_err  out  1  sticky fatal error flag.

Behaviour:
- FSM states: RUN, MEM_WAIT, TIMEOUT. Reset state is RUN and the wait counter resets to 0.
- Reset values of outputs:
  - all write enables = 1.
  - all bubble and flush outputs = 0.
  - mem_timeout_err = 0.
- Outputs are Mealy: combinational from state and current inputs, with zero latency.
- freeze is asserted when:
  - state is RUN or MEM_WAIT, and mem_req=1 and mem_ready=0; or
  - state is TIMEOUT (always).
- While freeze=1:
  - pc_write, if_id_write, id_ex_write and ex_mem_write are all 0.
  - mem_wb_bubble=1.
  - All flush outputs and id_ex_bubble are forced to 0.
- Flush: when freeze=0 and EX_MEM_BranchTaken=1, flush_if_id, flush_id_ex and flush_ex_mem are all 1. pc_write stays 1 so the redirect target loads.
- Load-use stall applies when all of the following hold:
  - freeze=0 and EX_MEM_BranchTaken=0;
  - ID_EX_MemRead=1 and ID_EX_Rd is not 0;
  - ID_EX_Rd equals IF_ID_Rs1, or (IF_ID_UsesRs2=1 and ID_EX_Rd equals IF_ID_Rs2).
- On a load-use stall: pc_write=0, if_id_write=0, id_ex_bubble=1. This lasts exactly one cycle because the bubble clears the hazard.
- Priority: freeze, then flush, then load-use stall, then normal run.
- Transitions:
  - RUN to MEM_WAIT when mem_req=1 and mem_ready=0; the counter loads 1.
  - MEM_WAIT to RUN when mem_ready=1; the freeze releases in that same cycle and the counter clears.
  - In MEM_WAIT with mem_ready=0, the counter increments. When the counter equals MEM_TIMEOUT-1 and mem_ready=0, go to TIMEOUT.
  - If mem_ready and the timeout condition occur in the same cycle, mem_ready wins and the FSM goes to RUN.
  - mem_req dropping to 0 while in MEM_WAIT returns the FSM to RUN (aborted access).
  - TIMEOUT is terminal until reset. mem_timeout_err=1 and the full freeze is held.
- A branch that arrives during a freeze is not lost. The frozen EX/MEM register keeps presenting it, so it is acted on in the first unfrozen cycle.
- Asserting rst_n low mid-wait returns to RUN immediately and clears mem_timeout_err.

Optional Feature:
HAZARD_PERF_CNT_EN: when defined, add the following outputs:
- stall_cnt[CNT_W-1:0]: counts load-use stall cycles.
- flush_cnt[CNT_W-1:0]: counts flush events.
- freeze_cnt[CNT_W-1:0]: counts frozen cycles.

The counters are saturating, reset to 0 and increment by 1 per qualifying cycle. When the macro is undefined these ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state typedef hz_state_t {RUN, MEM_WAIT, TIMEOUT};
  - localparam X0 = 5'd0;
  - the NOP-control zero constant shared with the pipeline registers.
- One natural sub-module: load_use_detect. It is purely combinational: register comparisons producing the raw hazard bit, which the FSM then qualifies.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs1=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then all writes=1.
- x0 and unused-rs2 cases:
  - ID_EX_MemRead=1, ID_EX_Rd=0, IF_ID_Rs1=0 -> no stall.
  - Rd=7, Rs2=7, UsesRs2=0 -> no stall.
- Branch beats load-use: EX_MEM_BranchTaken=1 while a load-use hazard is present -> all three flushes=1, id_ex_bubble=0, pc_write=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> freeze for 3 cycles (writes=0, mem_wb_bubble=1), released in the mem_ready cycle, state back to RUN.
- Timeout: mem_req=1, mem_ready held 0 with MEM_TIMEOUT=16 -> TIMEOUT reached after 16 frozen cycles and mem_timeout_err=1 sticky. rst_n low -> err=0, state RUN.
- Branch during freeze: EX_MEM_BranchTaken=1 together with a memory wait of 2 cycles -> flushes=0 during the wait, then flushes=1 in the release cycle.
